// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: operation codes from decode,
// result-class selectors, divider state encodings and common word constants.
package ex_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ZEROWORD      = '0;
  localparam logic              WRITE_ENABLE  = 1'b1;
  localparam logic              WRITE_DISABLE = 1'b0;

  // Result class (alusel)
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  // Operation codes (aluop)
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_CLZ_OP   = 8'b1011_0000;
  localparam logic [7:0] EXE_CLO_OP   = 8'b1011_0001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div_iter.sv
// Iterative restoring divider for DIV/DIVU.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, signed_div   divide presented this cycle / treat operands as signed
//   dividend, divisor   operands, held stable by the pipeline while stalled
//   annul               cancel the divide in flight
//   stall               stall request while the divide is pending
//   ready               final quotient/remainder valid (END state)
//   quo, rem            quotient (to LO) and remainder (to HI)
module ex_div_iter
  import ex_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              annul,
  output logic              stall,
  output logic              ready,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem
);

  localparam int CNT_W = $clog2(DIV_STEPS) + 1;

  div_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       acc;       // {partial remainder, dividend/quotient bits}
  logic [DATA_W-1:0] dvsr;
  logic              neg_quo;
  logic              neg_rem;
  logic [32:0]       trial;
  logic [63:0]       acc_step;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                    input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // One restoring step: shift in the next dividend bit and subtract the
  // divisor when it fits. The shifted remainder is below 2*divisor, so a
  // 33-bit trial difference is enough and its MSB is the borrow.
  always_comb begin
    trial = acc[63:31] - {1'b0, dvsr};
    if (trial[32]) acc_step = {acc[62:0], 1'b0};
    else           acc_step = {trial[31:0], acc[30:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      acc     <= '0;
      dvsr    <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      quo     <= '0;
      rem     <= '0;
    end else if (state != DIV_IDLE && annul) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !annul) begin
            cnt     <= '0;
            neg_quo <= signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_rem <= signed_div & dividend[DATA_W-1];
            if (divisor == ZEROWORD) begin
              state <= DIV_BYZERO;
            end else begin
              state <= DIV_ON;
              acc   <= {ZEROWORD, magnitude(dividend, signed_div)};
              dvsr  <= magnitude(divisor, signed_div);
            end
          end
        end
        DIV_BYZERO: begin
          quo   <= '1;
          rem   <= dividend;
          state <= DIV_END;
        end
        DIV_ON: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_STEPS - 1)) begin
            quo   <= cond_negate(acc_step[31:0], neg_quo);
            rem   <= cond_negate(acc_step[63:32], neg_rem);
            state <= DIV_END;
          end
        end
        DIV_END: state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign stall = (state == DIV_IDLE && start && !annul) ||
                 (state == DIV_BYZERO) || (state == DIV_ON);
  assign ready = (state == DIV_END) && !annul;

endmodule

// File: rtl/ex.sv
// MIPS execute stage: combinational logic/shift/move/arith/multiply datapath,
// HI/LO forwarding and output muxing, plus the iterative divider.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   aluop_i, alusel_i             operation and result class from decode
//   reg1_i, reg2_i                forwarded operands / immediate
//   wd_i, wreg_i                  destination register and write enable
//   hi_i, lo_i                    architectural HI/LO
//   mem_/wb_whilo_i, _hi_i, _lo_i pending HI/LO writes in MEM / WB
//   annul_i                       cancel an in-flight divide
//   wd_o, wreg_o, wdata_o         GPR write toward EX/MEM
//   whilo_o, hi_o, lo_o           HI/LO write toward EX/MEM
//   stallreq_o                    stall request while dividing
module ex
  import ex_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              mem_whilo_i,
  input  logic              wb_whilo_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  input  logic              annul_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  logic [DATA_W-1:0]        hi_fwd, lo_fwd;
  logic signed [DATA_W-1:0] op1_s, op2_s;
  logic signed [32:0]       add33, sub33;
  logic                     ov_add, ov_sub;
  logic signed [63:0]       prod_s;
  logic [63:0]              prod_u;
  logic [DATA_W-1:0]        logic_res, shift_res, move_res, arith_res;
  logic                     div_start, div_stall, div_ready;
  logic [DATA_W-1:0]        div_quo, div_rem;

  function automatic logic [5:0] lead_count(input logic [DATA_W-1:0] v, input logic b);
    logic [5:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (run && v[i] == b) n = n + 6'd1;
      else                  run = 1'b0;
    end
    return n;
  endfunction

  // The youngest pending HI/LO write wins.
  always_comb begin
    if (mem_whilo_i) begin
      hi_fwd = mem_hi_i;
      lo_fwd = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_fwd = wb_hi_i;
      lo_fwd = wb_lo_i;
    end else begin
      hi_fwd = hi_i;
      lo_fwd = lo_i;
    end
  end

  assign op1_s  = reg1_i;
  assign op2_s  = reg2_i;
  // Sign-extended to 33 bits: overflow shows up as bit 32 != bit 31.
  assign add33  = $signed({reg1_i[31], reg1_i}) + $signed({reg2_i[31], reg2_i});
  assign sub33  = $signed({reg1_i[31], reg1_i}) - $signed({reg2_i[31], reg2_i});
  assign ov_add = add33[32] ^ add33[31];
  assign ov_sub = sub33[32] ^ sub33[31];
  assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
  assign prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};

  always_comb begin
    logic_res = ZEROWORD;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = ZEROWORD;
    endcase
  end

  always_comb begin
    shift_res = ZEROWORD;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = op2_s >>> reg1_i[4:0];
      default:    shift_res = ZEROWORD;
    endcase
  end

  always_comb begin
    move_res = ZEROWORD;
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_fwd;
      EXE_MFLO_OP: move_res = lo_fwd;
      EXE_MOVN_OP,
      EXE_MOVZ_OP: move_res = reg1_i;
      default:     move_res = ZEROWORD;
    endcase
  end

  always_comb begin
    arith_res = ZEROWORD;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP: arith_res = add33[31:0];
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = sub33[31:0];
      EXE_SLT_OP:  arith_res = {31'b0, op1_s < op2_s};
      EXE_SLTU_OP: arith_res = {31'b0, reg1_i < reg2_i};
      EXE_CLZ_OP:  arith_res = {26'b0, lead_count(reg1_i, 1'b0)};
      EXE_CLO_OP:  arith_res = {26'b0, lead_count(reg1_i, 1'b1)};
      EXE_MUL_OP:  arith_res = prod_s[31:0];
      default:     arith_res = ZEROWORD;
    endcase
  end

  always_comb begin
    wdata_o = ZEROWORD;
    case (alusel_i)
      EXE_RES_LOGIC: wdata_o = logic_res;
      EXE_RES_SHIFT: wdata_o = shift_res;
      EXE_RES_MOVE:  wdata_o = move_res;
      EXE_RES_ARITH: wdata_o = arith_res;
      default:       wdata_o = ZEROWORD;
    endcase
  end

  assign wd_o = wd_i;

  always_comb begin
    wreg_o = wreg_i;
    case (aluop_i)
      EXE_ADD_OP:   if (ov_add) wreg_o = WRITE_DISABLE;
      EXE_SUB_OP:   if (ov_sub) wreg_o = WRITE_DISABLE;
      EXE_MULT_OP,
      EXE_MULTU_OP: wreg_o = WRITE_DISABLE;
      default:      wreg_o = wreg_i;
    endcase
  end

  always_comb begin
    whilo_o = WRITE_DISABLE;
    hi_o    = ZEROWORD;
    lo_o    = ZEROWORD;
    case (aluop_i)
      EXE_MULT_OP: begin
        whilo_o = WRITE_ENABLE;
        hi_o    = prod_s[63:32];
        lo_o    = prod_s[31:0];
      end
      EXE_MULTU_OP: begin
        whilo_o = WRITE_ENABLE;
        hi_o    = prod_u[63:32];
        lo_o    = prod_u[31:0];
      end
      EXE_MTHI_OP: begin
        whilo_o = WRITE_ENABLE;
        hi_o    = reg1_i;
        lo_o    = lo_fwd;
      end
      EXE_MTLO_OP: begin
        whilo_o = WRITE_ENABLE;
        hi_o    = hi_fwd;
        lo_o    = reg1_i;
      end
      EXE_DIV_OP, EXE_DIVU_OP: begin
        whilo_o = div_ready;
        hi_o    = div_rem;
        lo_o    = div_quo;
      end
      default: ;
    endcase
  end

  assign div_start = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  ex_div_iter #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (aluop_i == EXE_DIV_OP),
    .dividend   (reg1_i),
    .divisor    (reg2_i),
    .annul      (annul_i),
    .stall      (div_stall),
    .ready      (div_ready),
    .quo        (div_quo),
    .rem        (div_rem)
  );

  assign stallreq_o = div_stall;

endmodule

// File: tb/tb_ex.sv
module tb_ex;
  import ex_pkg::*;

  logic        clk, rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i, wb_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic        annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  ex #(.DIV_STEPS(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i), .mem_whilo_i(mem_whilo_i), .wb_whilo_i(wb_whilo_i),
    .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic        wreg;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic chk_wdata, input logic [31:0] wdata,
                      input logic wreg, input logic whilo,
                      input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.tag = tag; e.chk_wdata = chk_wdata; e.wdata = wdata; e.wreg = wreg;
    e.whilo = whilo; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the current outputs.
  task automatic check_out();
    exp_t e;
    chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.chk_wdata) chk({e.tag, ".wdata"}, wdata_o, e.wdata);
      chk({e.tag, ".wreg"},  {31'b0, wreg_o},  {31'b0, e.wreg});
      chk({e.tag, ".whilo"}, {31'b0, whilo_o}, {31'b0, e.whilo});
      if (e.whilo) begin
        chk({e.tag, ".hi"}, hi_o, e.hi);
        chk({e.tag, ".lo"}, lo_o, e.lo);
      end
    end
  endtask

  task automatic drive_nop();
    aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP;
    reg1_i = '0; reg2_i = '0; wreg_i = 1'b0; annul_i = 1'b0;
  endtask

  task automatic comb_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] exp_wdata, input logic exp_wreg,
                         input logic exp_whilo, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    @(posedge clk); #2;
    aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; wreg_i = 1'b1;
    push(tag, 1'b1, exp_wdata, exp_wreg, exp_whilo, exp_hi, exp_lo);
    #2;
    check_out();
  endtask

  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input int exp_stall, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int stalls;
    logic seen;
    @(posedge clk); #2;
    aluop_i = op; alusel_i = EXE_RES_NOP; reg1_i = r1; reg2_i = r2; wreg_i = 1'b0;
    push(tag, 1'b0, 32'h0, 1'b0, 1'b1, exp_hi, exp_lo);
    #2;
    stalls = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (whilo_o === 1'b1) begin
        seen = 1'b1;
        chk({tag, ".end_stall"}, {31'b0, stallreq_o}, 32'd0);
        check_out();
      end else begin
        if (stallreq_o === 1'b1) stalls++;
        @(posedge clk); #4;
      end
    end
    chk({tag, ".done"}, {31'b0, seen}, 32'd1);
    chk({tag, ".stall_cycles"}, stalls, exp_stall);
    if (!seen) sb.delete();
    drive_nop();
  endtask

  // DIVU 100/7 interrupted in ON cycle 10, by annul or by async reset.
  task automatic abort_div(input string tag, input logic use_rst);
    int whilo_hits, stall_hits;
    @(posedge clk); #2;
    aluop_i = EXE_DIVU_OP; alusel_i = EXE_RES_NOP; reg1_i = 32'd100; reg2_i = 32'd7;
    wreg_i = 1'b0;
    #2;
    chk({tag, ".accept_stall"}, {31'b0, stallreq_o}, 32'd1);
    repeat (10) @(posedge clk);
    #2;
    if (use_rst) begin
      rst = 1'b1;
      drive_nop();
      #2;
      chk({tag, ".stall_in_rst"}, {31'b0, stallreq_o}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
    end else begin
      annul_i = 1'b1;
      #2;
      chk({tag, ".stall_annul_cyc"}, {31'b0, stallreq_o}, 32'd1);
      @(posedge clk); #2;
      drive_nop();
      #2;
      chk({tag, ".stall_after"}, {31'b0, stallreq_o}, 32'd0);
    end
    whilo_hits = 0;
    stall_hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (whilo_o !== 1'b0) whilo_hits++;
      if (stallreq_o !== 1'b0) stall_hits++;
    end
    chk({tag, ".whilo_never"}, whilo_hits, 32'd0);
    chk({tag, ".stall_quiet"}, stall_hits, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_nop();
    wd_i = 5'd9;
    hi_i = 32'h1111_1111; lo_i = 32'h2222_2222;
    mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
    mem_hi_i = '0; mem_lo_i = '0; wb_hi_i = '0; wb_lo_i = '0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst.stall", {31'b0, stallreq_o}, 32'd0);
    chk("rst.whilo", {31'b0, whilo_o}, 32'd0);
    rst = 1'b0;
    #2;
    chk("post_rst.stall", {31'b0, stallreq_o}, 32'd0);
    chk("wd_pass", {27'b0, wd_o}, 32'd9);

    comb_op("add_ov",  EXE_ADD_OP,  EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 0, 0);
    comb_op("addu",    EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 0, 0);
    comb_op("sub_ov",  EXE_SUB_OP,  EXE_RES_ARITH, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 0);
    comb_op("sub_ok",  EXE_SUB_OP,  EXE_RES_ARITH, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 0);
    comb_op("lui",     EXE_OR_OP,   EXE_RES_LOGIC, 32'h0, 32'h1234_0000, 32'h1234_0000, 1'b1, 1'b0, 0, 0);
    comb_op("and",     EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 1'b0, 0, 0);
    comb_op("xor",     EXE_XOR_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 1'b0, 0, 0);
    comb_op("nor",     EXE_NOR_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b1, 1'b0, 0, 0);
    comb_op("sra",     EXE_SRA_OP,  EXE_RES_SHIFT, 32'h24, 32'h8000_0000, 32'hF800_0000, 1'b1, 1'b0, 0, 0);
    comb_op("srl",     EXE_SRL_OP,  EXE_RES_SHIFT, 32'h24, 32'h8000_0000, 32'h0800_0000, 1'b1, 1'b0, 0, 0);
    comb_op("sll",     EXE_SLL_OP,  EXE_RES_SHIFT, 32'd31, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 0, 0);
    comb_op("slt",     EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 1'b0, 0, 0);
    comb_op("sltu",    EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0, 0);
    comb_op("clz0",    EXE_CLZ_OP,  EXE_RES_ARITH, 32'h0, 32'h0, 32'd32, 1'b1, 1'b0, 0, 0);
    comb_op("clz15",   EXE_CLZ_OP,  EXE_RES_ARITH, 32'h0001_0000, 32'h0, 32'd15, 1'b1, 1'b0, 0, 0);
    comb_op("clo32",   EXE_CLO_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0, 32'd32, 1'b1, 1'b0, 0, 0);
    comb_op("clo4",    EXE_CLO_OP,  EXE_RES_ARITH, 32'hF000_0000, 32'h0, 32'd4, 1'b1, 1'b0, 0, 0);
    comb_op("mul",     EXE_MUL_OP,  EXE_RES_ARITH, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 1'b1, 1'b0, 0, 0);
    comb_op("mult",    EXE_MULT_OP, EXE_RES_NOP,   32'hFFFF_FFFE, 32'h3, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    comb_op("multu",   EXE_MULTU_OP,EXE_RES_NOP,   32'hFFFF_FFFE, 32'h3, 32'h0, 1'b0, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
    comb_op("movn",    EXE_MOVN_OP, EXE_RES_MOVE,  32'h0000_CAFE, 32'h1, 32'h0000_CAFE, 1'b1, 1'b0, 0, 0);
    comb_op("mfhi_arch", EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h1111_1111, 1'b1, 1'b0, 0, 0);

    mem_whilo_i = 1'b1; mem_hi_i = 32'hAAAA_0000; mem_lo_i = 32'h0000_0BBB;
    wb_whilo_i  = 1'b1; wb_hi_i  = 32'h0000_0001; wb_lo_i  = 32'h0000_0055;
    comb_op("mfhi_mem", EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'hAAAA_0000, 1'b1, 1'b0, 0, 0);
    mem_whilo_i = 1'b0;
    comb_op("mflo_wb",  EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h0000_0055, 1'b1, 1'b0, 0, 0);
    comb_op("mthi",     EXE_MTHI_OP, EXE_RES_NOP,  32'h0000_1234, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0055);
    wb_whilo_i = 1'b0;
    comb_op("mtlo",     EXE_MTLO_OP, EXE_RES_NOP,  32'h0000_5678, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1111_1111, 32'h0000_5678);
    comb_op("unknown",  8'hFF,       EXE_RES_LOGIC,32'h1234_5678, 32'h8765_4321, 32'h0, 1'b1, 1'b0, 0, 0);

    @(posedge clk); #2;
    drive_nop();

    run_div("div_m7_2",   EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("divu_5_0",   EXE_DIVU_OP, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);
    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_div("div_7_m2",   EXE_DIV_OP,  32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_div("div_min_m1", EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_div("divu_big",   EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h0001_0000, 33, 32'h0000_FFFF, 32'h0000_FFFF);

    abort_div("annul", 1'b0);
    run_div("after_annul", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    abort_div("arst", 1'b1);
    run_div("after_rst",   EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
